// File: rtl/seq_div8by4.sv
// seq_div8by4: multi-cycle unsigned restoring divider (DIVIDEND_W-bit dividend, DIVISOR_W-bit divisor)
// with valid/ready handshakes on both sides; one quotient bit per cycle, MSB first.
module seq_div8by4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  pr;
    logic [DIVISOR_W:0]    pr_sh;
    logic [DIVISOR_W-1:0]  pr_nx;
    logic [CW-1:0]         cnt;
    logic                  ge;

    assign in_ready = (state == IDLE) && !rst;

    // dq shifts dividend bits out of the top while quotient bits enter at the bottom;
    // the remainder after a successful subtract is always below dvs, so DIVISOR_W bits hold it.
    always_comb begin
        pr_sh = {pr, dq[DIVIDEND_W-1]};
        ge    = pr_sh >= {1'b0, dvs};
        pr_nx = ge ? DIVISOR_W'(pr_sh - {1'b0, dvs}) : pr_sh[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dq          <= '0;
            dvs         <= '0;
            pr          <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dq  <= dividend;
                        dvs <= divisor;
                        pr  <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dq  <= {dq[DIVIDEND_W-2:0], ge};
                    pr  <= pr_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DIVIDEND_W - 1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= {dq[DIVIDEND_W-2:0], ge};
                        remainder   <= pr_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div8by4.sv
// tb_seq_div8by4: randomized/exhaustive self-checking bench for seq_div8by4 against an
// arithmetic reference (/ and %, all-ones quotient for divide by zero).
module tb_seq_div8by4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       in_ready, out_valid, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int checks = 0;
    int errors = 0;

    seq_div8by4 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q;
        logic [3:0] r;
        if (b == 0) return {8'hFF, 4'h0, 1'b1};
        q = 8'(a / b);
        r = 4'(a % b);
        return {q, r, 1'b0};
    endfunction

    // Presents an operation and returns #1 after the edge where it was taken (ok=0 if never ready).
    task automatic accept(input logic [7:0] a, input logic [3:0] b, output bit ok);
        int w = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        dividend = 8'd5;
        divisor  = 4'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, quotient, remainder, div_by_zero} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b q=%0d r=%0d dbz=%b want all 0", out_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] av [3] = '{8'd200, 8'd225, 8'd255};
        logic [3:0] bv [3] = '{4'd13, 4'd15, 4'd1};
        logic [12:0] exp;
        bit ok;
        int n;
        for (int i = 0; i < 3; i++) begin
            exp = model(av[i], bv[i]);
            accept(av[i], bv[i], ok);
            wait_out(n);
            checks++;
            if (!ok || n != 9) begin errors++; $display("FAIL basic_latency %0d/%0d got %0d cycles (ok=%0d) want 9", av[i], bv[i], n, ok); end
            checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                errors++;
                $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                         av[i], bv[i], quotient, remainder, div_by_zero, exp[12:5], exp[4:1], exp[0]);
            end
            release_out();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_div_zero();
        bit ok;
        int n;
        accept(8'd7, 4'd0, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 1) begin errors++; $display("FAIL dbz_latency got %0d cycles want 1", n); end
        checks++;
        if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%0d dbz=%b want q=ff r=0 dbz=1", quotient, remainder, div_by_zero);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        accept(8'd100, 4'd7, ok);
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
        wait_out(n);
        checks++;
        if (!ok || n != 9) begin errors++; $display("FAIL bp_latency got %0d cycles want 9", n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || quotient !== 8'd14 || remainder !== 4'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ov=%b q=%0d r=%0d in_ready=%b want 1/14/2/0",
                         i, out_valid, quotient, remainder, in_ready);
            end
            @(negedge clk);
        end
        release_out();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(n);
        checks++;
        if (n != 9 || quotient !== 8'd16 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_pending got n=%0d q=%0d r=%0d dbz=%b want 9/16/2/0", n, quotient, remainder, div_by_zero);
        end
        release_out();
    endtask

    task automatic test_reset_busy();
        bit ok;
        bit seen = 0;
        int n;
        accept(8'd99, 4'd4, ok);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || {out_valid, quotient, remainder, div_by_zero} !== 14'd0) begin
            errors++;
            $display("FAIL rst_busy got in_ready=%b ov=%b q=%0d r=%0d dbz=%b want 1 and zeros",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_discard got out_valid=1 want no result"); end
        accept(8'd99, 4'd4, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 9 || quotient !== 8'd24 || remainder !== 4'd3) begin
            errors++;
            $display("FAIL rst_followup got n=%0d q=%0d r=%0d want 9/24/3", n, quotient, remainder);
        end
        release_out();
    endtask

    task automatic test_sweep();
        logic [12:0] exp;
        bit ok;
        int n;
        int done_cnt = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp = model(8'(a), 4'(b));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                accept(8'(a), 4'(b), ok);
                wait_out(n);
                if (out_valid) done_cnt++;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                checks++;
                if (!ok || n != (b == 0 ? 1 : 9) || out_valid !== 1'b1 || {quotient, remainder, div_by_zero} !== exp) begin
                    errors++;
                    $display("FAIL sweep %0d/%0d got n=%0d ov=%b q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                             a, b, n, out_valid, quotient, remainder, div_by_zero, exp[12:5], exp[4:1], exp[0]);
                end
                release_out();
            end
        end
        checks++;
        if (done_cnt != 4096) begin errors++; $display("FAIL sweep_count got %0d results want 4096", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_busy();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
